// File: rtl/gray2bin_seq_pkg.sv
// ---------------------------------------------------------------------------
// gray_pkg
//   Definitions shared by the Gray encoder/decoder blocks and their benches.
//   - GRAY_MAX_W  : widest supported word.
//   - gray_state_t: decoder FSM state encoding (IDLE / CONV / DONE).
//   - bin2gray()  : reference binary-to-Gray conversion, zero-extended to
//                   GRAY_MAX_W bits. Narrower callers slice the low bits.
// ---------------------------------------------------------------------------
package gray_pkg;

  localparam int unsigned GRAY_MAX_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } gray_state_t;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray2bin_seq_bit_step.sv
// ---------------------------------------------------------------------------
// gray_bit_step
//   One step of Gray-to-binary decoding. Each binary bit is the XOR of the
//   next-more-significant binary bit and the Gray bit at the same position.
//   Ports:
//     prev_bin  in  1  Already-resolved binary bit at position idx+1.
//     g_bit     in  1  Gray bit at position idx.
//     bin_bit   out 1  Resolved binary bit at position idx.
// ---------------------------------------------------------------------------
module gray_bit_step (
  input  logic prev_bin,
  input  logic g_bit,
  output logic bin_bit
);

  assign bin_bit = prev_bin ^ g_bit;

endmodule

// File: rtl/gray2bin_seq.sv
// ---------------------------------------------------------------------------
// gray2bin_seq
//   Sequential Gray-to-binary decoder. A Gray word is accepted through a
//   valid/ready handshake, one binary bit is resolved per clock (MSB first),
//   and the binary word is offered through a valid/ready handshake.
//   Parameters:
//     WIDTH      Word width in bits, 1..16.
//   Ports:
//     clk        in   1      Rising-edge clock.
//     rst        in   1      Synchronous active-high reset.
//     in_valid   in   1      in_gray carries a word to decode.
//     in_gray    in   WIDTH  Gray-coded input word.
//     in_ready   out  1      High in IDLE: a word can be accepted.
//     out_valid  out  1      High in DONE: out_bin carries the result.
//     out_bin    out  WIDTH  Decoded binary word.
//     out_ready  in   1      Consumer takes out_bin (only honoured in DONE).
//     busy       out  1      High in CONV or DONE.
// ---------------------------------------------------------------------------
module gray2bin_seq
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_gray,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_bin,
  input  logic             out_ready,
  output logic             busy
);

  // Index counter is at least one bit wide so WIDTH=1 still elaborates.
  localparam int unsigned IDXW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned IDX_START = (WIDTH > 1) ? WIDTH - 2 : 0;

  if (WIDTH == 0 || WIDTH > GRAY_MAX_W) begin : g_width_check
    $error("gray2bin_seq: WIDTH must be in 1..16");
  end

  gray_state_t      r_state;
  gray_state_t      w_state_nxt;
  logic [WIDTH-1:0] r_g;
  logic [WIDTH-1:0] r_bin;
  logic [IDXW-1:0]  r_idx;

  logic [WIDTH:0]   w_bin_ext;
  logic             w_prev_bin;
  logic             w_g_bit;
  logic             w_bit;
  logic             w_last;

  assign w_last = (r_idx == '0);

  // A constant zero above the MSB keeps the select loop in range for every
  // position, including WIDTH=1 where no CONV step is ever taken.
  assign w_bin_ext = {1'b0, r_bin};

  always_comb begin
    w_prev_bin = 1'b0;
    w_g_bit    = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_prev_bin = w_bin_ext[i+1];
        w_g_bit    = r_g[i];
      end
    end
  end

  gray_bit_step u_step (
    .prev_bin (w_prev_bin),
    .g_bit    (w_g_bit),
    .bin_bit  (w_bit)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_state_nxt = (WIDTH == 1) ? ST_DONE : ST_CONV;
        end
      end
      ST_CONV: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs decoded from state only
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      ST_IDLE: in_ready = 1'b1;
      ST_CONV: busy     = 1'b1;
      ST_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: latch the Gray word, seed the MSB, then resolve one bit per
  // cycle walking idx down to zero. r_bin is left alone in IDLE and DONE so
  // the last result stays visible until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_g   <= '0;
      r_bin <= '0;
      r_idx <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_g              <= in_gray;
            r_bin[WIDTH-1]   <= in_gray[WIDTH-1];
            r_idx            <= IDXW'(IDX_START);
          end
        end
        ST_CONV: begin
          for (int unsigned i = 0; i < WIDTH; i++) begin
            if (r_idx == IDXW'(i)) begin
              r_bin[i] <= w_bit;
            end
          end
          if (!w_last) begin
            r_idx <= r_idx - IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_bin = r_bin;

endmodule

// File: tb/tb_gray2bin_seq.sv
module tb_gray2bin_seq;
  import gray_pkg::*;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_gray;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_bin;
  logic       out_ready;
  logic       busy;

  logic       in_valid1;
  logic [0:0] in_gray1;
  logic       in_ready1;
  logic       out_valid1;
  logic [0:0] out_bin1;
  logic       out_ready1;
  logic       busy1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] sb_q[$];

  gray2bin_seq #(.WIDTH(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_gray   (in_gray),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_bin   (out_bin),
    .out_ready (out_ready),
    .busy      (busy)
  );

  gray2bin_seq #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_gray   (in_gray1),
    .in_ready  (in_ready1),
    .out_valid (out_valid1),
    .out_bin   (out_bin1),
    .out_ready (out_ready1),
    .busy      (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every completed output handshake consumes one expected word.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_output: got %0h with no word pending at %0t", out_bin, $time);
      end else begin
        logic [3:0] e;
        e = sb_q.pop_front();
        chk("sb_out_bin", 32'(out_bin), 32'(e));
      end
    end
  end

  // Offer one word, check the 3-cycle latency and handshake flags, and leave
  // the DUT in DONE. churn=1 scrambles in_valid/in_gray while it converts.
  task automatic send(input logic [3:0] g, input logic [3:0] b, input bit churn);
    int unsigned cyc;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("in_ready_before_accept", 32'(in_ready), 1);
    in_valid = 1'b1;
    in_gray  = g;
    sb_q.push_back(b);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("busy_in_conv", 32'(busy), 1);
    chk("in_ready_low_in_conv", 32'(in_ready), 0);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      if (churn) begin
        in_valid = 1'($urandom_range(0, 1));
        in_gray  = 4'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("latency", cyc, 3);
    chk("in_ready_low_in_done", 32'(in_ready), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_gray    = '0;
    out_ready  = 1'b1;
    in_valid1  = 1'b0;
    in_gray1   = '0;
    out_ready1 = 1'b1;

    // 1. Reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_bin",   32'(out_bin), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready",  32'(in_ready), 1);
    chk("rst_busy",      32'(busy), 0);
    chk("rst_w1_in_ready", 32'(in_ready1), 1);
    chk("rst_w1_out_bin",  32'(out_bin1), 0);
    rst = 1'b0;

    // 2. Basic decodes
    send(4'b0110, 4'b0100, 1'b0);
    send(4'b1000, 4'b1111, 1'b0);
    send(4'b1111, 4'b1010, 1'b0);
    send(4'b0000, 4'b0000, 1'b0);

    // 3. Exhaustive round trip through the reference encoder
    for (int b = 0; b < 16; b++) begin
      logic [GRAY_MAX_W-1:0] gg;
      gg = bin2gray(GRAY_MAX_W'(b));
      send(gg[3:0], 4'(b), 1'b0);
    end

    // 4. Backpressure
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(4'b1100, 4'b1000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_out_bin",   32'(out_bin), 'h8);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready",  32'(in_ready), 1);
    chk("bp_release_out_valid", 32'(out_valid), 0);
    chk("bp_hold_after_done",   32'(out_bin), 'h8);

    // 5. Reset in the second CONV cycle discards the word
    in_valid = 1'b1;
    in_gray  = 4'b1011;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready",  32'(in_ready), 1);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_bin",   32'(out_bin), 0);
    chk("midrst_busy",      32'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_output", 32'(out_valid), 0);
    end
    send(4'b0001, 4'b0001, 1'b0);

    // 6. Input churn during CONV/DONE
    send(4'b1010, 4'b1100, 1'b1);
    send(4'b0101, 4'b0110, 1'b1);
    send(4'b1001, 4'b1110, 1'b1);

    // 6b. WIDTH=1 build: result one cycle after accept
    in_valid1 = 1'b1;
    in_gray1  = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    chk("w1_out_valid", 32'(out_valid1), 1);
    chk("w1_out_bin",   32'(out_bin1), 1);
    chk("w1_busy",      32'(busy1), 1);
    @(posedge clk); #1;
    chk("w1_back_idle", 32'(in_ready1), 1);
    in_valid1 = 1'b1;
    in_gray1  = 1'b0;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    chk("w1_out_valid_zero", 32'(out_valid1), 1);
    chk("w1_out_bin_zero",   32'(out_bin1), 0);

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
